// File: rtl/lsu.sv
// Load/store unit: turns one EX-stage memory op into a single data-memory
// request over a req/ack handshake, stalls upstream while it is in flight,
// and returns extended load data to writeback. Bad accesses are flagged on
// err and never reach memory.
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic [31:0] load_data,
    output logic [4:0]  rd_out,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic        load_q, load_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] load_data_q, load_data_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        err_q, err_d;

    logic        bad_dir;
    logic        bad_f3;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    // Decode the incoming op: legality checks, byte enables and replicated store data
    always_comb begin
        bad_dir    = mem_read ~^ mem_write;
        bad_f3     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (mem_write && funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                     ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
        be_new     = 4'b1111;
        wdata_new  = store_data;
        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << alu_result[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_new    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = store_data;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (lane_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_data = {24'b0, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_data = {16'b0, half_sel};
            default: ext_data = dmem_rdata;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/WAIT/RESP sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        load_d      = load_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        load_data_d = load_data_q;
        rd_out_d    = rd_out_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (bad_dir || bad_f3 || misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {alu_result[31:2], 2'b00};
                        wdata_d = wdata_new;
                        be_d    = be_new;
                        f3_d    = funct3;
                        lane_d  = alu_result[1:0];
                        load_d  = mem_read;
                        rd_d    = rd;
                    end
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    if (load_q) begin
                        wb_valid_d  = 1'b1;
                        load_data_d = ext_data;
                        rd_out_d    = rd_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_C) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            f3_q        <= 3'd0;
            lane_q      <= 2'd0;
            load_q      <= 1'b0;
            rd_q        <= 5'd0;
            wb_valid_q  <= 1'b0;
            load_data_q <= 32'd0;
            rd_out_q    <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            load_q      <= load_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            load_data_q <= load_data_d;
            rd_out_q    <= rd_out_d;
            err_q       <= err_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wb_valid_q;
    assign load_data  = load_data_q;
    assign rd_out     = rd_out_q;
    assign err        = err_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the memory stage, directly downstream of the ALU. It takes the ALU result as the effective address, issues one data-memory request per load/store over a req/ack handshake, and stalls the pipeline until the request completes. It then returns sign- or zero-extended load data to writeback. Misaligned, malformed and timed-out accesses are dropped and flagged rather than issued.

## Interface
- `TIMEOUT`, 255: cycles in WAIT without `dmem_ack` before the access is abandoned (1..255).

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `valid_in`  in  1  EX stage presents a memory op this cycle.
- `mem_read`  in  1  op is a load.
- `mem_write`  in  1  op is a store.
- `funct3`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `alu_result`  in  32  effective byte address.
- `store_data`  in  32  rs2 value, low bits used.
- `rd`  in  5  load destination register.
- `busy`  out  1  stall upstream; high while state ≠ IDLE.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_rdata`  in  32  read word, valid when `dmem_ack`=1.
- `dmem_ack`  in  1  completion, one cycle.
- `wb_valid`  out  1  one-cycle pulse: `load_data`/`rd_out` valid.
- `load_data`  out  32  extended load result.
- `rd_out`  out  5  destination for `load_data`.
- `err`  out  1  one-cycle pulse: access dropped (misaligned, malformed, timeout).

## Operation
- States IDLE, WAIT, RESP. Reset: IDLE, all outputs 0, timeout counter 0.
- Accept: IDLE and `valid_in` and exactly one of `mem_read`/`mem_write`. Capture address, funct3, store data, rd, direction.
- `valid_in` with both or neither of `mem_read`/`mem_write` is malformed: `err` pulse, stay IDLE. Neither with `valid_in`=0 is a plain no-op.
- Malformed funct3 (011, 110, 111; store with funct3[2]=1): `err` pulse next cycle, stay IDLE, no request.
- Misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0): `err` pulse next cycle, stay IDLE, no request.
- Legal access: IDLE→WAIT. `dmem_req`=1, and addr/we/be/wdata are held constant for the whole of WAIT.
- Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011 (addr[1]=0) or 4'b1100; W = 4'b1111. The same enables are used for loads.
- Store data: B = {4{sd[7:0]}}; H = {2{sd[15:0]}}; W = sd.
- WAIT, `dmem_ack`=1 → RESP. `dmem_req` drops in the same edge. A load registers the extracted data.
  - Extraction: byte lane = addr[1:0], half lane = addr[1].
  - B/H are sign-extended; BU/HU are zero-extended.
- RESP → IDLE unconditionally. `wb_valid`=1 in RESP for loads only, including rd=0. Stores never assert `wb_valid`.
- Timeout: the counter increments each WAIT cycle without ack. On reaching `TIMEOUT`: WAIT→IDLE, `dmem_req` drops, `err` pulse next cycle, no `wb_valid`. The counter clears on entering WAIT.
- `dmem_ack` outside WAIT is ignored.
- `reset` mid-access forces IDLE with `dmem_req`=0 on that edge; no `wb_valid`/`err` follows.

## Timing
- Accept at edge ending cycle N → `dmem_req`, `busy` high from N+1.
- Ack sampled in cycle M ≥ N+1 → RESP in M+1 (`wb_valid`, `busy` still 1) → IDLE in M+2; next op accepted at the end of M+2.
- Minimum load-use latency: accept N, `wb_valid` N+2. Back-to-back throughput: one access per 3 cycles with zero-wait memory.
- Error pulses (`err`) occur in N+1 with `busy`=0; the next op can be accepted at the end of N+1.
- `load_data`/`rd_out` hold their last value outside `wb_valid`. All outputs are registered; `busy` is decoded from the state register.

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF, ack at N+1 → be 1111, addr 0x100, `wb_valid` at N+2 with load_data 0xDEADBEEF, rd_out echoed.
- LB addr 0x103, rdata 0x80123456 → be 1000, load_data 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 → 0x00008012.
- SB addr 0x201, sd 0x000000A5, ack after 3 wait cycles → we=1, addr 0x200, be 0010, wdata 0xA5A5A5A5, req stable all 4 WAIT cycles, no `wb_valid`.
- LW addr 0x102, and SH addr 0x103 → no `dmem_req`, `err` pulse at N+1, `busy` 0.
- `valid_in` with `mem_read`=`mem_write`=1 → no `dmem_req`, `err` pulse at N+1.
- TIMEOUT=4, no ack → req high 4 cycles then low, `err` pulse once, IDLE. Repeat with `reset` asserted in WAIT → req 0 next cycle, no `err`, a later ack is ignored.
